// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. Each byte is sent as a start bit (0),
// DATA_WIDTH data bits LSB first, an odd parity bit and a stop bit (1).
// One shift register carries the frame on the line; one holding register
// lets the next byte wait so frames can run back-to-back with no idle gap.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  txd_q, txd_d;

  logic accept;
  logic baud_end;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_WIDTH-1:0] b);
    return ~^b;
  endfunction

  assign accept   = in_valid && !hold_full_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, counters, buffering and the registered line level.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = 1'b1;

    // While a frame is on the line, an accepted byte waits in the holding
    // register (the final stop cycle below may route it straight through).
    if (accept && (state_q != S_IDLE)) begin
      hold_d      = in_byte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (accept) begin
          shift_d  = in_byte;
          parity_d = odd_parity(in_byte);
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (hold_full_q) begin
            // Pending byte starts immediately: zero idle gap.
            shift_d     = hold_q;
            parity_d    = odd_parity(hold_q);
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else if (accept) begin
            // Byte offered in the last stop cycle bypasses the holding register.
            shift_d     = in_byte;
            parity_d    = odd_parity(in_byte);
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // txd is registered, so it is derived from where the FSM is heading.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // Control state with asynchronous reset; an in-flight frame is abandoned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  // Data registers; only meaningful while qualified by the control state.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
    hold_q   <= hold_d;
  end

  assign txd      = txd_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_STOP) && baud_end;
  assign in_ready = !hold_full_q;

endmodule
